// File: rtl/sram_fifo_ctrl_if.sv
// Stream and SRAM-port bundle for sram_fifo_ctrl.
// slave is the controller's view, master is the producer/consumer/SRAM side.
interface sram_fifo_ctrl_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 256,
  localparam int W_ADDR = $clog2(DEPTH),
  localparam int W_LEVEL = $clog2(DEPTH + 3)
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;
  logic [W_LEVEL-1:0] level;
  logic [W_ADDR-1:0]  mem_waddr;
  logic [WIDTH-1:0]   mem_wdata;
  logic               mem_wen;
  logic [W_ADDR-1:0]  mem_raddr;
  logic               mem_ren;
  logic [WIDTH-1:0]   mem_rdata;

  modport slave (
    input  in_valid, in_data, out_ready, mem_rdata,
    output in_ready, out_valid, out_data, level,
           mem_waddr, mem_wdata, mem_wen, mem_raddr, mem_ren
  );

  modport master (
    output in_valid, in_data, out_ready, mem_rdata,
    input  in_ready, out_valid, out_data, level,
           mem_waddr, mem_wdata, mem_wen, mem_raddr, mem_ren
  );
endinterface

// File: rtl/sram_fifo_ctrl.sv
// Valid/ready FIFO controller for an external 1W/1R synchronous SRAM, with a
// 2-entry skid buffer that hides the one-cycle SRAM read latency.
module sram_fifo_ctrl #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 256,
  localparam int W_ADDR = $clog2(DEPTH),
  localparam int W_LEVEL = $clog2(DEPTH + 3)
) (
  input  logic clk,
  input  logic rst_n,
  sram_fifo_ctrl_if.slave bus
);
  localparam logic [W_ADDR:0] FULL = (W_ADDR + 1)'(DEPTH);

  logic [W_ADDR-1:0] wptr_reg;
  logic [W_ADDR-1:0] rptr_reg;
  logic [W_ADDR:0]   sram_level_reg;
  logic              rd_inflight_reg;
  logic [1:0]        skid_level_reg;
  logic [WIDTH-1:0]  skid0_reg;
  logic [WIDTH-1:0]  skid1_reg;

  logic       push;
  logic       pop;
  logic       ren;
  logic       capture;
  logic [1:0] occ_after;
  logic [1:0] cap_idx;

  assign bus.in_ready  = (sram_level_reg != FULL);
  assign bus.out_valid = (skid_level_reg != 2'd0);
  assign bus.out_data  = skid0_reg;

  assign push    = bus.in_valid & bus.in_ready;
  assign pop     = bus.out_valid & bus.out_ready;
  assign capture = rd_inflight_reg;

  // Skid occupancy once this cycle's capture and pop settle; a new read may
  // only be issued if its data will find a free skid slot next cycle.
  assign occ_after = skid_level_reg + {1'b0, rd_inflight_reg} - {1'b0, pop};
  assign ren       = (sram_level_reg != '0) && (occ_after < 2'd2);

  assign bus.mem_waddr = wptr_reg;
  assign bus.mem_wdata = bus.in_data;
  assign bus.mem_wen   = push;
  assign bus.mem_raddr = rptr_reg;
  assign bus.mem_ren   = ren;

  assign bus.level = W_LEVEL'(sram_level_reg) + W_LEVEL'(rd_inflight_reg)
                   + W_LEVEL'(skid_level_reg);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_reg        <= '0;
      rptr_reg        <= '0;
      sram_level_reg  <= '0;
      rd_inflight_reg <= 1'b0;
      skid_level_reg  <= 2'd0;
    end else begin
      if (push) wptr_reg <= wptr_reg + 1'b1;
      if (ren)  rptr_reg <= rptr_reg + 1'b1;
      sram_level_reg  <= sram_level_reg + (W_ADDR + 1)'(push) - (W_ADDR + 1)'(ren);
      rd_inflight_reg <= ren;
      skid_level_reg  <= skid_level_reg + 2'(capture) - 2'(pop);
    end
  end

  // Entry 0 is the head; a capture lands behind whatever survives the pop.
  assign cap_idx = pop ? (skid_level_reg - 2'd1) : skid_level_reg;

  always_ff @(posedge clk) begin
    if (capture && cap_idx == 2'd0)
      skid0_reg <= bus.mem_rdata;
    else if (pop)
      skid0_reg <= skid1_reg;
    if (capture && cap_idx == 2'd1)
      skid1_reg <= bus.mem_rdata;
  end
endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Directed bench for sram_fifo_ctrl (DEPTH=8) with a behavioural SRAM and a
// scoreboard queue for ordering and level.
module tb_sram_fifo_ctrl;
  localparam int WIDTH = 16;
  localparam int DEPTH = 8;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  logic last_push;
  logic [WIDTH-1:0] sb[$];
  logic [WIDTH-1:0] sram [DEPTH];

  sram_fifo_ctrl_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  sram_fifo_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (bus.mem_wen) sram[bus.mem_waddr] <= bus.mem_wdata;
    if (bus.mem_ren) bus.mem_rdata <= sram[bus.mem_raddr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: score the handshakes seen before the edge, then check level.
  task automatic cyc();
    logic p;
    logic q;
    #1;
    p = bus.in_valid & bus.in_ready;
    q = bus.out_valid & bus.out_ready;
    if (q) begin
      if (sb.size() == 0) check("pop_when_model_empty", 32'd1, 32'd0);
      else check("pop_data", 32'(bus.out_data), 32'(sb.pop_front()));
    end
    if (p) sb.push_back(bus.in_data);
    last_push = p;
    @(posedge clk);
    #1;
    check("level", 32'(bus.level), 32'(sb.size()));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sb.delete();
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_level", 32'(bus.level), 32'd0);
    check("rst_mem_ren", 32'(bus.mem_ren), 32'd0);
  endtask

  initial begin
    int idx;
    int bubbles;
    int maxl;
    int npush;
    logic started;
    n_checks = 0;
    n_fail = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // 1: single push, head visible two edges later
    bus.in_valid = 1'b1;
    bus.in_data = 16'h1234;
    #1;
    check("t1_mem_wen", 32'(bus.mem_wen), 32'd1);
    check("t1_mem_wdata", 32'(bus.mem_wdata), 32'h1234);
    check("t1_mem_waddr", 32'(bus.mem_waddr), 32'd0);
    cyc();
    bus.in_valid = 1'b0;
    check("t1_valid_e0", 32'(bus.out_valid), 32'd0);
    #1;
    check("t1_mem_ren", 32'(bus.mem_ren), 32'd1);
    check("t1_mem_raddr", 32'(bus.mem_raddr), 32'd0);
    cyc();
    check("t1_valid_e1", 32'(bus.out_valid), 32'd0);
    cyc();
    check("t1_valid_e2", 32'(bus.out_valid), 32'd1);
    check("t1_data_e2", 32'(bus.out_data), 32'h1234);
    check("t1_in_ready", 32'(bus.in_ready), 32'd1);
    cyc();
    check("t1_valid_held", 32'(bus.out_valid), 32'd1);

    // 2: drain, then stream 0..999 at full rate
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10 && sb.size() != 0; i++) cyc();
    check("t2_predrain", 32'(sb.size()), 32'd0);
    bubbles = 0;
    maxl = 0;
    npush = 0;
    started = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data = 16'(i);
      #1;
      if (started && !bus.out_valid) bubbles++;
      if (bus.out_valid) started = 1'b1;
      cyc();
      if (last_push) npush++;
      if (int'(bus.level) > maxl) maxl = int'(bus.level);
    end
    bus.in_valid = 1'b0;
    for (int i = 0; i < 20 && sb.size() != 0; i++) begin
      #1;
      if (!bus.out_valid) bubbles++;
      cyc();
    end
    check("t2_npush", 32'(npush), 32'd1000);
    check("t2_drained", 32'(sb.size()), 32'd0);
    check("t2_bubbles", 32'(bubbles), 32'd0);
    check("t2_maxlevel", 32'(maxl), 32'd3);

    // 3: fill under backpressure
    do_reset();
    idx = 0;
    for (int c = 0; c < 16; c++) begin
      bus.in_valid = (idx < 12);
      bus.in_data = 16'h0300 + 16'(idx);
      #1;
      if (bus.in_valid && !bus.in_ready) check("t3_wen_when_full", 32'(bus.mem_wen), 32'd0);
      cyc();
      if (last_push) idx++;
    end
    check("t3_accepted", 32'(idx), 32'd10);
    check("t3_level", 32'(bus.level), 32'd10);
    check("t3_in_ready", 32'(bus.in_ready), 32'd0);
    check("t3_head", 32'(bus.out_data), 32'h0300);

    // 5: full SRAM + full skid, pop with a pending push
    bus.in_valid = 1'b1;
    bus.in_data = 16'h030A;
    bus.out_ready = 1'b1;
    #1;
    check("t5_ren", 32'(bus.mem_ren), 32'd1);
    check("t5_raddr", 32'(bus.mem_raddr), 32'd2);
    check("t5_wen_blocked", 32'(bus.mem_wen), 32'd0);
    cyc();
    bus.out_ready = 1'b0;
    check("t5_in_ready", 32'(bus.in_ready), 32'd1);
    #1;
    check("t5_wen", 32'(bus.mem_wen), 32'd1);
    check("t5_waddr", 32'(bus.mem_waddr), 32'd2);
    cyc();
    if (last_push) idx++;
    check("t5_accepted", 32'(idx), 32'd11);
    bus.out_ready = 1'b1;
    for (int c = 0; c < 40 && (idx < 12 || sb.size() != 0); c++) begin
      bus.in_valid = (idx < 12);
      bus.in_data = 16'h0300 + 16'(idx);
      cyc();
      if (last_push) idx++;
    end
    check("t3_all_accepted", 32'(idx), 32'd12);
    check("t3_drained", 32'(sb.size()), 32'd0);

    // 4: random handshakes across pointer wrap
    idx = 0;
    for (int c = 0; c < 600 && (idx < 40 || sb.size() != 0); c++) begin
      bus.in_valid = (idx < 40) ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.in_data = 16'h4000 + 16'(idx);
      bus.out_ready = (idx < 40) ? 1'($urandom_range(0, 1)) : 1'b1;
      cyc();
      if (last_push) idx++;
    end
    check("t4_accepted", 32'(idx), 32'd40);
    check("t4_drained", 32'(sb.size()), 32'd0);

    // 6: reset with a read in flight and five entries held
    do_reset();
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data = 16'h0600 + 16'(i);
      cyc();
    end
    bus.in_data = 16'h0605;
    bus.out_ready = 1'b1;
    #1;
    check("t6_ren", 32'(bus.mem_ren), 32'd1);
    cyc();
    check("t6_level_pre", 32'(bus.level), 32'd5);
    do_reset();
    bus.in_valid = 1'b1;
    bus.in_data = 16'hBEEF;
    cyc();
    bus.in_valid = 1'b0;
    check("t6_valid_e0", 32'(bus.out_valid), 32'd0);
    cyc();
    check("t6_valid_e1", 32'(bus.out_valid), 32'd0);
    cyc();
    check("t6_valid_e2", 32'(bus.out_valid), 32'd1);
    check("t6_data_e2", 32'(bus.out_data), 32'hBEEF);
    bus.out_ready = 1'b1;
    cyc();
    check("t6_alone_valid", 32'(bus.out_valid), 32'd0);
    check("t6_alone_level", 32'(bus.level), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
